// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared types and constants for the reaction-timer game core.
//   state_e    : round FSM states; the encodings are the o_dst display codes
//   bcd_time_t : six packed BCD digits, ms hundreds..units then us hundreds..units
//   LFSR_*     : seed and Galois tap mask for x^16+x^14+x^13+x^11
//   lfsr_next  : one right-shifting Galois LFSR step
// -----------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_WAIT = 3'b001,
        ST_GO   = 3'b010,
        ST_MISS = 3'b011,
        ST_HIT  = 3'b110
    } state_e;

    typedef logic [23:0] bcd_time_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Bits 15,13,12,10 toggle on feedback: x^16, x^14, x^13, x^11 terms.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam bcd_time_t   BCD_MAX   = 24'h999999;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] shifted;
        shifted = {1'b0, v[15:1]};
        if (v[0]) begin
            lfsr_next = shifted ^ LFSR_TAPS;
        end else begin
            lfsr_next = shifted;
        end
    endfunction

endpackage

// File: rtl/bcd_counter6.sv
// -----------------------------------------------------------------------------
// bcd_counter6
// Six-digit BCD up-counter that saturates at 999999 instead of wrapping.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (value -> 0)
//   i_clr  : synchronous clear, wins over i_inc
//   i_inc  : add one (ignored once saturated)
//   o_val  : current count, 24-bit packed BCD
//   o_max  : count is 999999
// -----------------------------------------------------------------------------
module bcd_counter6
    import reaction_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_clr,
    input  logic      i_inc,
    output bcd_time_t o_val,
    output logic      o_max
);

    bcd_time_t r_val;
    bcd_time_t w_inc_val;

    assign o_val = r_val;
    assign o_max = (r_val == BCD_MAX);

    // Ripple-carry BCD increment: a digit steps only when every lower digit is 9.
    always_comb begin
        logic carry;
        w_inc_val = r_val;
        carry     = 1'b1;
        for (int d = 0; d < 6; d++) begin
            if (carry) begin
                if (r_val[d*4 +: 4] == 4'd9) begin
                    w_inc_val[d*4 +: 4] = 4'd0;
                end else begin
                    w_inc_val[d*4 +: 4] = r_val[d*4 +: 4] + 4'd1;
                end
            end else begin
                w_inc_val[d*4 +: 4] = r_val[d*4 +: 4];
            end
            carry = carry & (r_val[d*4 +: 4] == 4'd9);
        end
    end

    // Count register: clear has priority, increment stops at all-nines.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_val <= 24'h000000;
        end else if (i_clr) begin
            r_val <= 24'h000000;
        end else if (i_inc && !o_max) begin
            r_val <= w_inc_val;
        end else begin
            r_val <= r_val;
        end
    end

endmodule

// File: rtl/reaction_core.sv
// -----------------------------------------------------------------------------
// reaction_core
// Round FSM for the reaction timer: idle -> random wait -> go -> hit/miss.
// Measures reaction time in BCD ms.us, keeps last and best times.
//   i_clk    : system clock (CLK_HZ, integer multiple of 1 MHz)
//   i_rst    : synchronous active-high reset
//   i_btn    : button level, already synchronized/debounced
//   i_bcdmux : 0 -> o_bcd shows last time, 1 -> best time
//   o_dst    : display state code (registered)
//   o_bcd    : selected time, combinational from i_bcdmux
//   o_lit    : in GO (registered)
//   o_miss   : in MISS (registered)
//   o_init   : no HIT since reset, best not yet valid (registered)
// -----------------------------------------------------------------------------
module reaction_core
    import reaction_pkg::*;
#(
    parameter int CLK_HZ      = 25_000_000,
    parameter int MIN_WAIT_MS = 1000,
    parameter int RAND_BITS   = 11
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_btn,
    input  logic        i_bcdmux,
    output logic [2:0]  o_dst,
    output logic [23:0] o_bcd,
    output logic        o_lit,
    output logic        o_miss,
    output logic        o_init
);

    localparam int US_DIV   = CLK_HZ / 1_000_000;
    localparam int PRE_W    = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int WAIT_MAX = MIN_WAIT_MS + (1 << RAND_BITS);
    localparam int WAIT_W   = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    state_e              r_state;
    logic                r_btn_q;
    logic [15:0]         r_lfsr;
    logic [PRE_W-1:0]    r_pre;
    logic [9:0]          r_msd;
    logic [WAIT_W-1:0]   r_wait;
    bcd_time_t           r_last;
    bcd_time_t           r_best;
    logic                r_init;
    logic [2:0]          r_dst;
    logic                r_lit;
    logic                r_miss;

    state_e              w_state_nxt;
    logic                w_press;
    logic                w_us_tick;
    logic                w_ms_tick;
    logic                w_entry;
    logic                w_load_last;
    logic                w_cnt_clr;
    logic                w_cnt_inc;
    logic                w_cnt_max;
    bcd_time_t           w_cnt;

    assign w_press   = i_btn & ~r_btn_q;
    assign w_us_tick = (r_pre == PRE_W'(US_DIV - 1));
    assign w_ms_tick = w_us_tick & (r_msd == 10'd999);
    assign w_entry   = (w_state_nxt != r_state);
    assign w_cnt_clr = w_entry & (w_state_nxt == ST_GO);
    assign w_cnt_inc = (r_state == ST_GO) & w_us_tick;

    assign o_dst  = r_dst;
    assign o_lit  = r_lit;
    assign o_miss = r_miss;
    assign o_init = r_init;
    assign o_bcd  = i_bcdmux ? r_best : r_last;

    bcd_counter6 u_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_val (w_cnt),
        .o_max (w_cnt_max)
    );

    // Button history; follows the pin even in reset so a level held
    // through reset release is not mistaken for a fresh press.
    always_ff @(posedge i_clk) begin
        r_btn_q <= i_btn;
    end

    // Free-running LFSR, advances every cycle in every state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // Next-state logic; a press always beats wait expiry and saturation.
    always_comb begin
        w_state_nxt = r_state;
        w_load_last = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_press) begin
                    w_state_nxt = ST_MISS;
                end else if (w_ms_tick && (r_wait == {WAIT_W{1'b0}})) begin
                    w_state_nxt = ST_GO;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_GO: begin
                if (w_press) begin
                    w_state_nxt = ST_HIT;
                    w_load_last = 1'b1;
                end else if (w_cnt_max) begin
                    w_state_nxt = ST_MISS;
                end else begin
                    w_state_nxt = ST_GO;
                end
            end
            ST_HIT, ST_MISS: begin
                if (w_press) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus outputs decoded from the next state so they line up.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_dst   <= 3'b000;
            r_lit   <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dst   <= w_state_nxt;
            r_lit   <= (w_state_nxt == ST_GO);
            r_miss  <= (w_state_nxt == ST_MISS);
        end
    end

    // us prescaler and ms divider, restarted on every state entry.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_entry) begin
            r_pre <= {PRE_W{1'b0}};
            r_msd <= 10'd0;
        end else if (w_us_tick) begin
            r_pre <= {PRE_W{1'b0}};
            if (r_msd == 10'd999) begin
                r_msd <= 10'd0;
            end else begin
                r_msd <= r_msd + 10'd1;
            end
        end else begin
            r_pre <= r_pre + PRE_W'(1);
            r_msd <= r_msd;
        end
    end

    // Random wait: load on WAIT entry, count ms ticks down to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait <= {WAIT_W{1'b0}};
        end else if (w_entry && (w_state_nxt == ST_WAIT)) begin
            r_wait <= WAIT_W'(MIN_WAIT_MS) + WAIT_W'(r_lfsr[RAND_BITS-1:0]);
        end else if ((r_state == ST_WAIT) && w_ms_tick && (r_wait != {WAIT_W{1'b0}})) begin
            r_wait <= r_wait - WAIT_W'(1);
        end else begin
            r_wait <= r_wait;
        end
    end

    // Last/best capture on HIT; BCD order matches numeric order, so a
    // plain unsigned compare works. Ties leave best alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 24'h000000;
            r_best <= 24'h000000;
            r_init <= 1'b1;
        end else if (w_load_last) begin
            r_last <= w_cnt;
            if (r_init || (w_cnt < r_best)) begin
                r_best <= w_cnt;
            end else begin
                r_best <= r_best;
            end
            r_init <= 1'b0;
        end else begin
            r_last <= r_last;
            r_best <= r_best;
            r_init <= r_init;
        end
    end

endmodule

// File: tb/tb_reaction_core.sv
// -----------------------------------------------------------------------------
// tb_reaction_core
// Self-checking bench for reaction_core with a small clock (2 MHz model,
// 1 ms minimum wait, 2 random bits). Expected times come from elapsed-cycle
// arithmetic, the wait length from an LFSR model, best/last from a scoreboard.
// -----------------------------------------------------------------------------
module tb_reaction_core;

    localparam int CLK_HZ      = 2_000_000;
    localparam int MIN_WAIT_MS = 1;
    localparam int RAND_BITS   = 2;
    localparam int US_DIV      = CLK_HZ / 1_000_000;
    localparam int MS_CYC      = US_DIV * 1000;

    localparam logic [2:0] D_IDLE = 3'b000;
    localparam logic [2:0] D_WAIT = 3'b001;
    localparam logic [2:0] D_GO   = 3'b010;
    localparam logic [2:0] D_MISS = 3'b011;
    localparam logic [2:0] D_HIT  = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn;
    logic        bcdmux;
    logic [2:0]  o_dst;
    logic [23:0] o_bcd;
    logic        o_lit;
    logic        o_miss;
    logic        o_init;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [15:0] m_lfsr;
    int          m_last_us;
    int          m_best_us;
    logic        m_init;
    int          w;

    reaction_core #(
        .CLK_HZ      (CLK_HZ),
        .MIN_WAIT_MS (MIN_WAIT_MS),
        .RAND_BITS   (RAND_BITS)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_btn    (btn),
        .i_bcdmux (bcdmux),
        .o_dst    (o_dst),
        .o_bcd    (o_bcd),
        .o_lit    (o_lit),
        .o_miss   (o_miss),
        .o_init   (o_init)
    );

    always #5 clk = ~clk;

    // Galois LFSR x^16+x^14+x^13+x^11, shifting right.
    function automatic logic [15:0] lfsr_model(input logic [15:0] v);
        logic [15:0] s;
        s = {1'b0, v[15:1]};
        if (v[0]) begin
            s[15] = ~s[15];
            s[13] = ~s[13];
            s[12] = ~s[12];
            s[10] = ~s[10];
        end
        return s;
    endfunction

    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lfsr_model(m_lfsr);

    function automatic logic [23:0] to_bcd(input int us);
        logic [23:0] b;
        int          v;
        v = us;
        b = 24'h000000;
        for (int d = 0; d < 6; d++) begin
            b[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic press();
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic model_hit(input int us);
        m_last_us = us;
        if (m_init || (us < m_best_us)) m_best_us = us;
        m_init = 1'b0;
    endtask

    task automatic check_times(input string tag);
        bcdmux = 1'b0;
        #1;
        check_eq({tag, "_last"}, 32'(o_bcd), 32'(to_bcd(m_last_us)));
        bcdmux = 1'b1;
        #1;
        check_eq({tag, "_best"}, 32'(o_bcd), 32'(to_bcd(m_best_us)));
        bcdmux = 1'b0;
        check_eq({tag, "_init"}, 32'(o_init), 32'(m_init));
    endtask

    task automatic start_round(output int wait_ms, input string tag);
        @(negedge clk);
        wait_ms = MIN_WAIT_MS + int'(m_lfsr) % (1 << RAND_BITS);
        press();
        check_eq({tag, "_wait_dst"}, 32'(o_dst), 32'(D_WAIT));
    endtask

    task automatic wait_go(input int wait_ms, input string tag);
        int n;
        n = 0;
        while ((o_lit !== 1'b1) && (n < 12000)) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_go_delay"}, 32'(n), 32'(MS_CYC * (wait_ms + 1)));
        check_eq({tag, "_go_dst"}, 32'(o_dst), 32'(D_GO));
    endtask

    task automatic hit_at(input int react, input string tag);
        repeat (react) @(negedge clk);
        press();
        model_hit(react / US_DIV);
        check_eq({tag, "_hit_dst"}, 32'(o_dst), 32'(D_HIT));
        check_eq({tag, "_hit_lit"}, 32'(o_lit), 32'd0);
        check_times(tag);
    endtask

    initial begin
        #(10 * 150_000);
        $display("FAIL watchdog: no finish after %0d cycles", 150_000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        btn       = 1'b1;
        bcdmux    = 1'b0;
        m_last_us = 0;
        m_best_us = 0;
        m_init    = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_dst", 32'(o_dst), 32'(D_IDLE));
        check_eq("rst_lit", 32'(o_lit), 32'd0);
        check_eq("rst_miss", 32'(o_miss), 32'd0);
        check_times("rst");

        // Button held across reset release must not start a round.
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("held_btn_dst", 32'(o_dst), 32'(D_IDLE));
        btn = 1'b0;
        @(negedge clk);

        // False start.
        start_round(w, "fs");
        repeat (100) @(negedge clk);
        press();
        check_eq("fs_dst", 32'(o_dst), 32'(D_MISS));
        check_eq("fs_miss", 32'(o_miss), 32'd1);
        check_times("fs");

        // Directed rounds: 1234 us, 2000 us (slower), 500 us (new best).
        start_round(w, "r1");
        wait_go(w, "r1");
        hit_at(US_DIV * 1234, "r1");
        start_round(w, "r2");
        wait_go(w, "r2");
        hit_at(US_DIV * 2000, "r2");
        start_round(w, "r3");
        wait_go(w, "r3");
        hit_at(US_DIV * 500, "r3");

        // Random reaction lengths.
        for (int i = 0; i < 2; i++) begin
            start_round(w, "rnd");
            wait_go(w, "rnd");
            hit_at(int'($urandom_range(1500, 0)), "rnd");
        end

        // Timeout: counter pinned at 999999, no press -> MISS next cycle.
        start_round(w, "sat");
        wait_go(w, "sat");
        repeat (10) @(negedge clk);
        force dut.u_cnt.r_val = 24'h999999;
        check_eq("sat_pre_dst", 32'(o_dst), 32'(D_GO));
        @(negedge clk);
        check_eq("sat_dst", 32'(o_dst), 32'(D_MISS));
        check_eq("sat_miss", 32'(o_miss), 32'd1);
        check_eq("sat_lit", 32'(o_lit), 32'd0);
        release dut.u_cnt.r_val;
        check_times("sat");

        // Press on the saturation cycle counts as HIT at 999.999.
        start_round(w, "satp");
        wait_go(w, "satp");
        repeat (10) @(negedge clk);
        force dut.u_cnt.r_val = 24'h999999;
        press();
        release dut.u_cnt.r_val;
        model_hit(999999);
        check_eq("satp_dst", 32'(o_dst), 32'(D_HIT));
        check_times("satp");

        // Reset in the middle of GO aborts the round.
        start_round(w, "mrst");
        wait_go(w, "mrst");
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_last_us = 0;
        m_best_us = 0;
        m_init    = 1'b1;
        check_eq("mrst_dst", 32'(o_dst), 32'(D_IDLE));
        check_eq("mrst_lit", 32'(o_lit), 32'd0);
        check_times("mrst");
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
